ebtb_mem_ctrl: RTL and testbench
================================

// Module: ebtb_mem_ctrl
// PURPOSE
//  Initiator side of the 128x40 eBTB 1R1W array: drives its R0 (read) and W0 (write) ports.
//  Zeroes the array after reset and on flush, since the macro has no reset.
//  Serves frontend lookups with 1-cycle latency and forwards same-cycle same-index updates.
//  Sits between the BPD frontend lookup/update paths and the ebtb_128x40 macro.
// PARAMETERS
//  DEPTH  128  number of array entries; AW = $clog2(DEPTH)
//  AW     7    index width
//  DW     40   entry width
// PORTS
//  clock        in   1   sole clock; also drives macro R0_clk/W0_clk
//  reset_n      in   1   asynchronous, active-low reset
//  flush        in   1   pulse: re-zero whole array (ignored while already in INIT)
//  init_done    out  1   1 = array zeroed, lookups/updates accepted
//  req_valid    in   1   lookup request
//  req_ready    out  1   = init_done
//  req_idx      in   AW  lookup index
//  resp_valid   out  1   lookup result valid, exactly 1 cycle after req accept
//  resp_idx     out  AW  index of the returned entry
//  resp_data    out  DW  entry data; 0 when resp_valid=0
//  upd_valid    in   1   update (write) request
//  upd_ready    out  1   = init_done
//  upd_idx      in   AW  update index
//  upd_data     in   DW  update data
//  mem_r_en     out  1   to macro R0_en
//  mem_r_addr   out  AW  to macro R0_addr
//  mem_r_data   in   DW  from macro R0_data (valid cycle after mem_r_en)
//  mem_w_en     out  1   to macro W0_en
//  mem_w_addr   out  AW  to macro W0_addr
//  mem_w_data   out  DW  to macro W0_data
// BEHAVIOUR
//  Reset (async, reset_n=0): state=INIT, cnt=0, init_done=0, resp_valid=0, resp_idx=0, fwd flag=0,
//    all mem_* enables 0 while reset asserted; resp_data=0.
//  FSM: INIT -> READY when the write of cnt==DEPTH-1 issues; READY -> INIT on flush=1 (cnt<=0).
//  INIT: mem_w_en=1, mem_w_addr=cnt, mem_w_data=0, cnt++ each cycle; req_ready=upd_ready=0;
//    mem_r_en=0. Exactly DEPTH write cycles; init_done=1 from the cycle after the last one.
//  READY: req_ready=upd_ready=1 combinationally (1R1W; no arbitration, read and write concurrent).
//    Read accept (req_valid): mem_r_en=1, mem_r_addr=req_idx; next cycle resp_valid=1,
//      resp_idx=registered req_idx, resp_data=mem_r_data (or forwarded data, below).
//    Update accept (upd_valid): mem_w_en=1, mem_w_addr=upd_idx, mem_w_data=upd_data, same cycle.
//    Collision (read and update accepted same cycle, req_idx==upd_idx): latch upd_data; next cycle
//      resp_data=latched upd_data, not mem_r_data (macro collision result never relied on).
//    Update in the cycle a response is presented does not affect that response.
//    Back-to-back reads: one response per cycle, in order; no backpressure on resp.
//  flush in READY: requests/updates accepted that cycle complete normally (the response is still
//    delivered next cycle); INIT starts next cycle and overwrites the update with zero.
//  resp_valid=0 => resp_data forced to 0 (no X from macro leaks out).
//  Reset mid-INIT or mid-READY: immediate return to reset state; sweep restarts at index 0.
// TESTING
//  Release reset -> 128 cycles mem_w_en=1, addr 0..127, data 0; init_done=1 at cycle 128; readies 0 before.
//  Update idx 5 = 40'h12_3456_789A, read idx 5 next cycle -> resp_valid 1 cycle later, data 40'h123456789A.
//  Same cycle: update idx 9 = 40'hAA_AAAA_AAAA and read idx 9 -> resp_data 40'hAAAAAAAAAA; read idx 10 -> 0.
//  After writes to idx 5/9, pulse flush -> init_done=0 for 128 cycles; then read idx 5 -> 0.
//  Assert reset_n=0 at sweep cnt=40 -> mem_w_en, init_done, resp_valid 0 immediately; restart at addr 0.
//  Reads idx 0..127 every cycle after writing data=idx -> 128 consecutive responses, resp_idx=resp_data=idx.

Source files
------------

// File: rtl/ebtb_mem_ctrl.sv
// Initiator for the 1R1W eBTB array: zero-sweeps the macro after reset/flush,
// serves 1-cycle lookups, and forwards same-cycle same-index updates to the response.
module ebtb_mem_ctrl #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 40
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          flush,
    output logic          init_done,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_idx,
    output logic          resp_valid,
    output logic [AW-1:0] resp_idx,
    output logic [DW-1:0] resp_data,
    input  logic          upd_valid,
    output logic          upd_ready,
    input  logic [AW-1:0] upd_idx,
    input  logic [DW-1:0] upd_data,
    output logic          mem_r_en,
    output logic [AW-1:0] mem_r_addr,
    input  logic [DW-1:0] mem_r_data,
    output logic          mem_w_en,
    output logic [AW-1:0] mem_w_addr,
    output logic [DW-1:0] mem_w_data
);

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] cnt;
    logic          rd_acc, wr_acc, coll;
    logic          fwd_q;
    logic [DW-1:0] fwd_data_q;

    assign init_done = (state == S_READY);
    assign req_ready = init_done;
    assign upd_ready = init_done;
    assign coll      = rd_acc && wr_acc && (req_idx == upd_idx);

    always_comb begin
        state_nxt  = state;
        rd_acc     = 1'b0;
        wr_acc     = 1'b0;
        mem_r_en   = 1'b0;
        mem_r_addr = '0;
        mem_w_en   = 1'b0;
        mem_w_addr = '0;
        mem_w_data = '0;
        case (state)
            S_INIT: begin
                // Macro has no reset: keep the sweep write quiet while reset is held.
                mem_w_en   = reset_n;
                mem_w_addr = cnt;
                if (cnt == AW'(DEPTH - 1))
                    state_nxt = S_READY;
            end
            S_READY: begin
                rd_acc     = req_valid;
                wr_acc     = upd_valid;
                mem_r_en   = req_valid;
                mem_r_addr = req_idx;
                mem_w_en   = upd_valid;
                mem_w_addr = upd_idx;
                mem_w_data = upd_data;
                if (flush)
                    state_nxt = S_INIT;
            end
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_INIT)
                cnt <= cnt + 1'b1;
            else if (flush)
                cnt <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid <= 1'b0;
            resp_idx   <= '0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            resp_valid <= rd_acc;
            fwd_q      <= coll;
            if (rd_acc)
                resp_idx <= req_idx;
            if (coll)
                fwd_data_q <= upd_data;
        end
    end

    // Macro collision output is never trusted; X from an idle macro never escapes.
    assign resp_data = !resp_valid ? '0 : (fwd_q ? fwd_data_q : mem_r_data);

endmodule

// File: tb/tb_ebtb_mem_ctrl.sv
// Directed bench for ebtb_mem_ctrl with a behavioural 128x40 1R1W macro model
// (read returns pre-write contents on a same-address collision).
module tb_ebtb_mem_ctrl;
    localparam int DEPTH = 128;
    localparam int AW    = 7;
    localparam int DW    = 40;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          init_done;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_idx = '0;
    logic          resp_valid;
    logic [AW-1:0] resp_idx;
    logic [DW-1:0] resp_data;
    logic          upd_valid = 1'b0;
    logic          upd_ready;
    logic [AW-1:0] upd_idx = '0;
    logic [DW-1:0] upd_data = '0;
    logic          mem_r_en;
    logic [AW-1:0] mem_r_addr;
    logic [DW-1:0] mem_r_data;
    logic          mem_w_en;
    logic [AW-1:0] mem_w_addr;
    logic [DW-1:0] mem_w_data;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ebtb_mem_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush), .init_done(init_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
        .resp_valid(resp_valid), .resp_idx(resp_idx), .resp_data(resp_data),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_idx(upd_idx), .upd_data(upd_data),
        .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
        .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data)
    );

    // Macro model: registered read of old contents, write lands at the edge.
    logic [DW-1:0] mdl [DEPTH];
    always @(posedge clock) begin
        if (mem_r_en) mem_r_data <= mdl[mem_r_addr];
        if (mem_w_en) mdl[mem_w_addr] <= mem_w_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the falling edge.
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        upd_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic wait_init(input string tag, output int n);
        n = 0;
        while (!init_done && n < 300) begin
            tick();
            n++;
        end
        chk(tag, 64'(init_done), 64'd1);
    endtask

    int n;
    int sweep_err;

    initial begin
        tick();
        // Reset state
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        chk("rst_mem_w_en", 64'(mem_w_en), 64'd0);
        chk("rst_mem_r_en", 64'(mem_r_en), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);

        // Zero sweep: 128 write cycles, addr 0..127, data 0, readies low
        reset_n = 1'b1;
        #1;
        sweep_err = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!(mem_w_en === 1'b1 && mem_w_addr === AW'(i) && mem_w_data === '0 &&
                  req_ready === 1'b0 && upd_ready === 1'b0 && init_done === 1'b0 &&
                  mem_r_en === 1'b0))
                sweep_err++;
            tick();
        end
        chk("sweep_cycles_bad", 64'(sweep_err), 64'd0);
        chk("init_done_at_128", 64'(init_done), 64'd1);
        chk("req_ready_ready", 64'(req_ready), 64'd1);
        chk("upd_ready_ready", 64'(upd_ready), 64'd1);
        chk("idle_resp_data", 64'(resp_data), 64'd0);

        // Update idx 5, then read it back
        upd_valid = 1'b1; upd_idx = 7'd5; upd_data = 40'h12_3456_789A;
        #1;
        chk("upd_w_en", 64'(mem_w_en), 64'd1);
        chk("upd_w_addr", 64'(mem_w_addr), 64'd5);
        chk("upd_w_data", 64'(mem_w_data), 64'h12_3456_789A);
        tick();
        upd_valid = 1'b0; req_valid = 1'b1; req_idx = 7'd5;
        #1;
        chk("rd_r_en", 64'(mem_r_en), 64'd1);
        chk("rd_r_addr", 64'(mem_r_addr), 64'd5);
        chk("rd_no_resp_yet", 64'(resp_valid), 64'd0);
        tick();
        idle();
        chk("rd5_valid", 64'(resp_valid), 64'd1);
        chk("rd5_idx", 64'(resp_idx), 64'd5);
        chk("rd5_data", 64'(resp_data), 64'h12_3456_789A);
        tick();
        chk("rd5_single", 64'(resp_valid), 64'd0);

        // Collision forward on idx 9
        upd_valid = 1'b1; upd_idx = 7'd9; upd_data = 40'hAA_AAAA_AAAA;
        req_valid = 1'b1; req_idx = 7'd9;
        tick();
        chk("coll_valid", 64'(resp_valid), 64'd1);
        chk("coll_data", 64'(resp_data), 64'hAA_AAAA_AAAA);
        // Update during a presented response must not disturb it
        upd_idx = 7'd9; upd_data = 40'h55_5555_5555;
        req_idx = 7'd10;
        #1;
        chk("coll_data_hold", 64'(resp_data), 64'hAA_AAAA_AAAA);
        chk("coll_idx", 64'(resp_idx), 64'd9);
        tick();
        upd_valid = 1'b0;
        req_idx = 7'd9;
        chk("rd10_idx", 64'(resp_idx), 64'd10);
        chk("rd10_data", 64'(resp_data), 64'd0);
        tick();
        idle();
        chk("rd9_new", 64'(resp_data), 64'h55_5555_5555);
        tick();

        // Flush with a concurrent read of 9 and update of 5
        flush = 1'b1; req_valid = 1'b1; req_idx = 7'd9;
        upd_valid = 1'b1; upd_idx = 7'd5; upd_data = 40'h77_7777_7777;
        tick();
        idle();
        chk("flush_resp_valid", 64'(resp_valid), 64'd1);
        chk("flush_resp_data", 64'(resp_data), 64'h55_5555_5555);
        chk("flush_init_done", 64'(init_done), 64'd0);
        chk("flush_sweep_addr0", 64'(mem_w_addr), 64'd0);
        wait_init("flush_init_timeout", n);
        chk("flush_init_cycles", 64'(n), 64'd128);
        req_valid = 1'b1; req_idx = 7'd5;
        tick();
        idle();
        chk("flush_rd5_valid", 64'(resp_valid), 64'd1);
        chk("flush_rd5_zero", 64'(resp_data), 64'd0);

        // Reset while a response is presented
        req_valid = 1'b1; req_idx = 7'd9;
        tick();
        idle();
        chk("pre_rst_valid", 64'(resp_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_ready_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_ready_resp_data", 64'(resp_data), 64'd0);
        chk("rst_ready_init_done", 64'(init_done), 64'd0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("restart_addr0", 64'(mem_w_addr), 64'd0);

        // Reset mid-sweep at cnt=40
        for (int i = 0; i < 40; i++) tick();
        chk("mid_sweep_addr40", 64'(mem_w_addr), 64'd40);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_w_en", 64'(mem_w_en), 64'd0);
        chk("mid_rst_init_done", 64'(init_done), 64'd0);
        chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("mid_restart_w_en", 64'(mem_w_en), 64'd1);
        chk("mid_restart_addr0", 64'(mem_w_addr), 64'd0);
        wait_init("mid_init_timeout", n);
        chk("mid_init_cycles", 64'(n), 64'd128);

        // Fill data=idx, then back-to-back reads of every entry
        for (int i = 0; i < DEPTH; i++) begin
            upd_valid = 1'b1; upd_idx = AW'(i); upd_data = DW'(i);
            tick();
        end
        idle();
        sweep_err = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            req_valid = (i < DEPTH);
            req_idx   = AW'(i);
            #1;
            if (i > 0 && !(resp_valid === 1'b1 && resp_idx === AW'(i - 1) &&
                           resp_data === DW'(i - 1)))
                sweep_err++;
            tick();
        end
        idle();
        chk("b2b_bad_resps", 64'(sweep_err), 64'd0);
        chk("b2b_drained", 64'(resp_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end
endmodule
